// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_pkg
//  Description : Shared ALU types and constants: flag bundle, op-mode
//                encodings, default datapath width and flag decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int   c_default_width = 32;

    // Op-mode encodings (Sub / Signed inputs)
    localparam logic c_op_add        = 1'b0;
    localparam logic c_op_sub        = 1'b1;
    localparam logic c_mode_unsigned = 1'b0;
    localparam logic c_mode_signed   = 1'b1;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic negative;
    } alu_flags_t;

    // Overflow from final carry c, operand MSBs am / bm (bm already inverted
    // for subtract) and the wrapped sum MSB sm.
    function automatic logic calc_overflow(input logic sgn, input logic sub,
                                           input logic c, input logic am,
                                           input logic bm, input logic sm);
        if (sgn == c_mode_signed)
            return (am & bm & ~sm) | (~am & ~bm & sm);
        else if (sub == c_op_sub)
            return ~c;              // borrow
        else
            return c;
    endfunction

    // Sign of the exact, unbounded result.
    function automatic logic calc_negative(input logic sgn, input logic sub,
                                           input logic c, input logic am,
                                           input logic bm, input logic sm);
        if (sgn == c_mode_signed)
            return (am ^ bm) ? sm : am;
        else if (sub == c_op_sub)
            return ~c;              // borrow means A < B
        else
            return 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_seg_stage.sv
`default_nettype none
// ============================================================================
//  Module      : add_seg_stage
//  Description : One carry segment of the pipelined adder. Adds a SEG_WIDTH
//                slice plus carry-in and registers sum, carry-out and valid.
//                All registers hold when i_en is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_seg_stage #(
    parameter int SEG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [SEG_WIDTH-1:0] i_a,
    input  logic [SEG_WIDTH-1:0] i_b,
    input  logic                 i_cin,
    input  logic                 i_valid,
    output logic [SEG_WIDTH-1:0] o_sum,
    output logic                 o_cout,
    output logic                 o_valid
);

    logic [SEG_WIDTH:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{SEG_WIDTH{1'b0}}, i_cin};

    // Register the segment sum, its carry-out and the stage valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            o_sum   <= '0;
            o_cout  <= 1'b0;
            o_valid <= 1'b0;
        end else if (i_en) begin
            {o_cout, o_sum} <= w_total;
            o_valid         <= i_valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_add_sub
//  Description : Carry-segmented pipelined adder/subtractor with valid/ready
//                handshake, global stall and Zero/Overflow/Negative flags.
//                Latency is STAGES = WIDTH/SEG_WIDTH cycles.
//                Optional macro ADD_SATURATE_EN adds a Saturate input that
//                clamps S on overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Signed,
    input  logic             Sub,
`ifdef ADD_SATURATE_EN
    input  logic             Saturate,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Zero,
    output logic             Overflow,
    output logic             Negative
);

    localparam int STAGES = WIDTH / SEG_WIDTH;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % SEG_WIDTH != 0) begin : g_width_check
        $error("pipelined_add_sub: WIDTH must be a multiple of SEG_WIDTH");
    end

    logic w_stall;
    logic w_en;

    // The whole pipeline freezes while a finished result is not taken
    assign w_stall  = out_valid & ~out_ready;
    assign w_en     = ~w_stall;
    assign in_ready = ~w_stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W  = WIDTH - k * SEG_WIDTH;                  // operand bits not yet added
        localparam int HI_W  = (k == LAST) ? 1 : IN_W - SEG_WIDTH;     // bits forwarded (MSB only at the end)
        localparam int ACC_W = (k + 1) * SEG_WIDTH;                    // sum bits complete after this stage

        logic [IN_W-1:0]      w_a_in;
        logic [IN_W-1:0]      w_b_in;
        logic                 w_cin;
        logic                 w_vin;
        logic                 w_signed_in;
        logic                 w_sub_in;
        logic [SEG_WIDTH-1:0] w_seg_sum;
        logic                 w_cout;
        logic                 w_vout;
        logic [ACC_W-1:0]     w_sum_acc;
        logic [HI_W-1:0]      r_a_hi;
        logic [HI_W-1:0]      r_b_hi;
        logic                 r_signed;
        logic                 r_sub;
`ifdef ADD_SATURATE_EN
        logic                 w_sat_in;
        logic                 r_sat;
`endif

        if (k == 0) begin : g_first
            // B is inverted and Sub is the carry-in, giving A + ~B + 1
            assign w_a_in      = A;
            assign w_b_in      = B ^ {WIDTH{Sub}};
            assign w_cin       = Sub;
            assign w_vin       = in_valid & in_ready;
            assign w_signed_in = Signed;
            assign w_sub_in    = Sub;
`ifdef ADD_SATURATE_EN
            assign w_sat_in    = Saturate;
`endif
            assign w_sum_acc   = w_seg_sum;
        end else begin : g_next
            logic [k*SEG_WIDTH-1:0] r_lo;

            assign w_a_in      = g_stage[k-1].r_a_hi;
            assign w_b_in      = g_stage[k-1].r_b_hi;
            assign w_cin       = g_stage[k-1].w_cout;
            assign w_vin       = g_stage[k-1].w_vout;
            assign w_signed_in = g_stage[k-1].r_signed;
            assign w_sub_in    = g_stage[k-1].r_sub;
`ifdef ADD_SATURATE_EN
            assign w_sat_in    = g_stage[k-1].r_sat;
`endif
            assign w_sum_acc   = {w_seg_sum, r_lo};

            // Carry the already-finished low sum slices alongside the op
            always_ff @(posedge clk) begin
                if (reset)
                    r_lo <= '0;
                else if (w_en)
                    r_lo <= g_stage[k-1].w_sum_acc;
            end
        end

        if (k == LAST) begin : g_msb
            // Final stage keeps only the operand MSBs needed by the flags
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                end else if (w_en) begin
                    r_a_hi <= w_a_in[IN_W-1];
                    r_b_hi <= w_b_in[IN_W-1];
                end
            end
        end else begin : g_hi
            // Forward the operand bits that later stages still have to add
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                end else if (w_en) begin
                    r_a_hi <= w_a_in[IN_W-1:SEG_WIDTH];
                    r_b_hi <= w_b_in[IN_W-1:SEG_WIDTH];
                end
            end
        end

        // Delay the op-mode bits with the data
        always_ff @(posedge clk) begin
            if (reset) begin
                r_signed <= 1'b0;
                r_sub    <= 1'b0;
`ifdef ADD_SATURATE_EN
                r_sat    <= 1'b0;
`endif
            end else if (w_en) begin
                r_signed <= w_signed_in;
                r_sub    <= w_sub_in;
`ifdef ADD_SATURATE_EN
                r_sat    <= w_sat_in;
`endif
            end
        end

        add_seg_stage #(
            .SEG_WIDTH (SEG_WIDTH)
        ) u_seg (
            .clk     (clk),
            .rst     (reset),
            .i_en    (w_en),
            .i_a     (w_a_in[SEG_WIDTH-1:0]),
            .i_b     (w_b_in[SEG_WIDTH-1:0]),
            .i_cin   (w_cin),
            .i_valid (w_vin),
            .o_sum   (w_seg_sum),
            .o_cout  (w_cout),
            .o_valid (w_vout)
        );
    end

    logic [WIDTH-1:0] w_wrapped;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;
    logic             w_neg;
    alu_flags_t       w_flags;

    assign w_wrapped = g_stage[LAST].w_sum_acc;

    // Flags decoded from the final stage registers, so they are stable while stalled
    assign w_ovf = calc_overflow(g_stage[LAST].r_signed, g_stage[LAST].r_sub,
                                 g_stage[LAST].w_cout, g_stage[LAST].r_a_hi[0],
                                 g_stage[LAST].r_b_hi[0], w_wrapped[WIDTH-1]);
    assign w_neg = calc_negative(g_stage[LAST].r_signed, g_stage[LAST].r_sub,
                                 g_stage[LAST].w_cout, g_stage[LAST].r_a_hi[0],
                                 g_stage[LAST].r_b_hi[0], w_wrapped[WIDTH-1]);

`ifdef ADD_SATURATE_EN
    // Clamp the result toward the side the exact result overflowed to
    always_comb begin
        w_result = w_wrapped;
        if (g_stage[LAST].r_sat && w_ovf) begin
            if (g_stage[LAST].r_signed == c_mode_signed)
                w_result = w_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else if (g_stage[LAST].r_sub == c_op_sub)
                w_result = '0;
            else
                w_result = '1;
        end
    end
`else
    assign w_result = w_wrapped;
`endif

    assign w_flags = '{zero:     (w_result == '0) & ~w_ovf,
                       overflow: w_ovf,
                       negative: w_neg};

    // Flags read as 0 when no result is present (including just after reset)
    assign out_valid = g_stage[LAST].w_vout;
    assign S         = w_result;
    assign Zero      = w_flags.zero     & out_valid;
    assign Overflow  = w_flags.overflow & out_valid;
    assign Negative  = w_flags.negative & out_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_add_sub
//  Description : Directed self-checking bench for pipelined_add_sub
//                (WIDTH=32, SEG_WIDTH=8, latency 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_add_sub;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Signed;
    logic        Sub;
    logic        sat_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] S;
    logic        Zero;
    logic        Overflow;
    logic        Negative;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_add_sub #(
        .WIDTH     (32),
        .SEG_WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Signed    (Signed),
        .Sub       (Sub),
`ifdef ADD_SATURATE_EN
        .Saturate  (sat_req),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .Negative  (Negative)
    );

    // Offer one op, then step to the cycle its result must appear (accept + 4)
    task automatic issue_op(input logic [31:0] a, input logic [31:0] b,
                            input logic sgn, input logic sub, input logic sat,
                            output int early);
        @(negedge clk);
        A = a; B = b; Signed = sgn; Sub = sub; sat_req = sat;
        in_valid = 1'b1; out_ready = 1'b1;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) early++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Signed = 1'b0; Sub = 1'b0; sat_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({out_valid, S, Zero, Overflow, Negative} !== 36'h0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b S=%h Z=%b O=%b N=%b expected all 0",
                     out_valid, S, Zero, Overflow, Negative);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b expected=1", in_ready);
        end
    endtask

    task automatic test_signed_overflow;
        int early;
        issue_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, early);
        checks++;
        if (early !== 0 || out_valid !== 1'b1) begin
            failures++; $display("FAIL sadd_latency early=%0d valid=%b expected early=0 valid=1", early, out_valid);
        end
        checks++;
        if ({S, Zero, Overflow, Negative} !== {32'h8000_0000, 3'b010}) begin
            failures++; $display("FAIL sadd_ovf got S=%h ZON=%b%b%b expected S=80000000 ZON=010", S, Zero, Overflow, Negative);
        end
`ifdef ADD_SATURATE_EN
        issue_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1, early);
        checks++;
        if ({out_valid, S, Zero, Overflow, Negative} !== {1'b1, 32'h7FFF_FFFF, 3'b010}) begin
            failures++; $display("FAIL sadd_sat got S=%h ZON=%b%b%b expected S=7fffffff ZON=010", S, Zero, Overflow, Negative);
        end
        issue_op(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 1'b1, early);
        checks++;
        if ({out_valid, S, Zero, Overflow, Negative} !== {1'b1, 32'h0000_0000, 3'b011}) begin
            failures++; $display("FAIL usub_sat got S=%h ZON=%b%b%b expected S=00000000 ZON=011", S, Zero, Overflow, Negative);
        end
`endif
    endtask

    task automatic test_sub_modes;
        int early;
        issue_op(32'd3, 32'd5, 1'b0, 1'b1, 1'b0, early);
        checks++;
        if ({out_valid, S, Zero, Overflow, Negative} !== {1'b1, 32'hFFFF_FFFE, 3'b011}) begin
            failures++; $display("FAIL usub_borrow got S=%h ZON=%b%b%b expected S=fffffffe ZON=011", S, Zero, Overflow, Negative);
        end
        issue_op(32'd3, 32'd5, 1'b1, 1'b1, 1'b0, early);
        checks++;
        if ({out_valid, S, Zero, Overflow, Negative} !== {1'b1, 32'hFFFF_FFFE, 3'b001}) begin
            failures++; $display("FAIL ssub_neg got S=%h ZON=%b%b%b expected S=fffffffe ZON=001", S, Zero, Overflow, Negative);
        end
    endtask

    task automatic test_zero_and_wrap;
        int early;
        issue_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b0, early);
        checks++;
        if ({out_valid, S, Zero, Overflow, Negative} !== {1'b1, 32'h0, 3'b100}) begin
            failures++; $display("FAIL ssub_zero got S=%h ZON=%b%b%b expected S=00000000 ZON=100", S, Zero, Overflow, Negative);
        end
        issue_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, early);
        checks++;
        if ({out_valid, S, Zero, Overflow, Negative} !== {1'b1, 32'h0, 3'b010}) begin
            failures++; $display("FAIL uadd_wrap got S=%h ZON=%b%b%b expected S=00000000 ZON=010", S, Zero, Overflow, Negative);
        end
    endtask

    task automatic test_carry_ripple;
        int early;
        issue_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, early);
        checks++;
        if ({out_valid, S, Zero, Overflow, Negative} !== {1'b1, 32'h0100_0000, 3'b000}) begin
            failures++; $display("FAIL uadd_ripple got S=%h ZON=%b%b%b expected S=01000000 ZON=000", S, Zero, Overflow, Negative);
        end
        issue_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, early);
        checks++;
        if ({out_valid, S, Zero, Overflow, Negative} !== {1'b1, 32'h0, 3'b011}) begin
            failures++; $display("FAIL sadd_negovf got S=%h ZON=%b%b%b expected S=00000000 ZON=011", S, Zero, Overflow, Negative);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a_q   [8];
        logic [31:0] b_q   [8];
        logic [31:0] exp_q [8];
        int tx = 0, rx = 0, low = 0, low_wrong = 0, bad = 0, extra = 0;
        for (int i = 0; i < 8; i++) begin
            a_q[i]   = 32'h00FF_FFF0 + 32'h0101_0101 * i;
            b_q[i]   = 32'h0000_0010 + i;
            exp_q[i] = a_q[i] + b_q[i];
        end
        for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_valid  = (tx < 8);
            A = a_q[tx % 8]; B = b_q[tx % 8]; Signed = 1'b0; Sub = 1'b0; sat_req = 1'b0;
            #1;
            if (!in_ready) begin
                low++;
                if (cyc < 6 || cyc > 8) low_wrong++;
            end else if (cyc >= 6 && cyc <= 8) begin
                low_wrong++;
            end
            if (out_valid) begin
                if (rx >= 8 || S !== exp_q[rx]) bad++;
                else if (out_ready) rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++;
        if (tx !== 8 || rx !== 8) begin
            failures++; $display("FAIL b2b_count got tx=%0d rx=%0d expected 8/8", tx, rx);
        end
        checks++;
        if (low !== 3 || low_wrong !== 0) begin
            failures++; $display("FAIL b2b_in_ready got low=%0d misplaced=%0d expected 3/0", low, low_wrong);
        end
        checks++;
        if (bad !== 0 || extra !== 0) begin
            failures++; $display("FAIL b2b_order got bad=%0d extra=%0d expected 0/0", bad, extra);
        end
    endtask

    task automatic test_reset_inflight;
        int early;
        int late = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            A = 32'hAAAA_0000 + i; B = 32'h0; Signed = 1'b0; Sub = 1'b0; sat_req = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1; A = 32'hAAAA_0003;          // offered while reset wins
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, S, Zero, Overflow, Negative} !== 36'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_flush got valid=%b S=%h ZON=%b%b%b ready=%b expected 0/0/000/1",
                     out_valid, S, Zero, Overflow, Negative, in_ready);
        end
        issue_op(32'd5, 32'd7, 1'b0, 1'b0, 1'b0, early);
        checks++;
        if (early !== 0) begin
            failures++; $display("FAIL rst_ghost got early_valid=%0d expected=0", early);
        end
        checks++;
        if ({out_valid, S, Zero, Overflow, Negative} !== {1'b1, 32'd12, 3'b000}) begin
            failures++; $display("FAIL rst_fresh got valid=%b S=%h expected valid=1 S=0000000c", out_valid, S);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) late++;
        end
        checks++;
        if (late !== 0) begin
            failures++; $display("FAIL rst_late got extra_valid=%0d expected=0", late);
        end
    endtask

    initial begin
        test_reset;
        test_signed_overflow;
        test_sub_modes;
        test_zero_and_wrap;
        test_carry_ripple;
        test_back_to_back;
        test_reset_inflight;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
